// File: rtl/bp_pkg.sv
// Shared types for the fetch-stage branch predictor and its execute-stage feedback.
package bp_pkg;

  typedef logic [31:0] u32_t;

  // Branch-unit operation reported with each resolved branch.
  typedef enum logic [3:0] {
    BEQ  = 4'd0,
    BNE  = 4'd1,
    BLT  = 4'd2,
    BLTU = 4'd3,
    BGE  = 4'd4,
    BGEU = 4'd5,
    B    = 4'd6,
    BL   = 4'd7,
    JIRL = 4'd8
  } bru_op_t;

endpackage

// File: rtl/branch_predictor_if.sv
// Lookup and training bus between the fetch/execute stages and the branch predictor.
interface branch_predictor_if;
  import bp_pkg::*;

  // fetch-side lookup
  logic    pred_valid;
  u32_t    pred_pc;
  logic    pred_taken;
  u32_t    pred_target;

  // execute-side training
  logic    upd_valid;
  u32_t    upd_pc;
  bru_op_t upd_op;
  logic    upd_ret;
  logic    upd_taken;
  u32_t    upd_target;
  logic    upd_mispredict;

  modport master (
    output pred_valid, pred_pc,
    output upd_valid, upd_pc, upd_op, upd_ret, upd_taken, upd_target, upd_mispredict,
    input  pred_taken, pred_target
  );

  modport slave (
    input  pred_valid, pred_pc,
    input  upd_valid, upd_pc, upd_op, upd_ret, upd_taken, upd_target, upd_mispredict,
    output pred_taken, pred_target
  );

endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters and a return-address stack.
// Lookup is combinational from pred_pc; training and RAS updates land on the clock edge.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int BTB_ENTRIES = 64,
  parameter int RAS_DEPTH   = 8
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bp
);

  localparam int IW = $clog2(BTB_ENTRIES);
  localparam int TW = 30 - IW;
  localparam int RW = $clog2(RAS_DEPTH);
  localparam logic [RW:0] RAS_FULL = (RW+1)'(RAS_DEPTH);

  typedef enum logic [1:0] {T_COND, T_JUMP, T_CALL, T_RET} btb_type_t;

  // BTB storage (flop-based: the lookup must be combinational)
  logic          valid_reg  [BTB_ENTRIES];
  logic [TW-1:0] tag_reg    [BTB_ENTRIES];
  u32_t          target_reg [BTB_ENTRIES];
  btb_type_t     type_reg   [BTB_ENTRIES];
  logic [1:0]    ctr_reg    [BTB_ENTRIES];

  // RAS storage: tp_reg points at the current top, cnt_reg is occupancy
  u32_t          ras_reg [RAS_DEPTH];
  logic [RW-1:0] tp_reg;
  logic [RW:0]   cnt_reg;

  // lookup side
  logic [IW-1:0] pred_idx;
  logic [TW-1:0] pred_tag;
  logic          pred_hit;
  btb_type_t     pred_type;
  u32_t          pred_seq;
  logic          ras_empty;
  logic          ras_push;
  logic          ras_pop;
  logic          ras_clear;
  logic [RW-1:0] tp_inc;

  assign pred_idx  = bp.pred_pc[IW+1:2];
  assign pred_tag  = bp.pred_pc[31:IW+2];
  assign pred_hit  = valid_reg[pred_idx] && (tag_reg[pred_idx] == pred_tag);
  assign pred_type = type_reg[pred_idx];
  assign pred_seq  = bp.pred_pc + 32'd4;
  assign ras_empty = (cnt_reg == '0);
  assign tp_inc    = tp_reg + 1'b1;

  assign ras_push  = bp.pred_valid && pred_hit && (pred_type == T_CALL);
  assign ras_pop   = bp.pred_valid && pred_hit && (pred_type == T_RET) && !ras_empty;
  assign ras_clear = bp.upd_valid && bp.upd_mispredict;

  // Next-PC guess; a RET with an empty stack falls back to the last seen target
  always_comb begin
    bp.pred_taken  = 1'b0;
    bp.pred_target = pred_seq;
    if (pred_hit) begin
      case (pred_type)
        T_COND: begin
          if (ctr_reg[pred_idx][1]) begin
            bp.pred_taken  = 1'b1;
            bp.pred_target = target_reg[pred_idx];
          end
        end
        T_RET: begin
          bp.pred_taken  = 1'b1;
          bp.pred_target = ras_empty ? target_reg[pred_idx] : ras_reg[tp_reg];
        end
        default: begin
          bp.pred_taken  = 1'b1;
          bp.pred_target = target_reg[pred_idx];
        end
      endcase
    end
  end

  // training side
  logic [IW-1:0] upd_idx;
  logic [TW-1:0] upd_tag;
  logic          upd_hit;
  btb_type_t     upd_type;
  logic [1:0]    ctr_cur;
  logic [1:0]    ctr_next;

  assign upd_idx = bp.upd_pc[IW+1:2];
  assign upd_tag = bp.upd_pc[31:IW+2];
  assign upd_hit = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);
  assign ctr_cur = ctr_reg[upd_idx];

  // Classify the resolved branch; a non-return JIRL is treated as an indirect jump
  always_comb begin
    upd_type = T_COND;
    case (bp.upd_op)
      B:       upd_type = T_JUMP;
      BL:      upd_type = T_CALL;
      JIRL:    upd_type = bp.upd_ret ? T_RET : T_JUMP;
      default: upd_type = T_COND;
    endcase
  end

  // Saturating 2-bit direction counter step
  always_comb begin
    ctr_next = ctr_cur;
    if (bp.upd_taken) begin
      if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'b01;
    end else begin
      if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'b01;
    end
  end

  // BTB training: refresh on hit, allocate only taken misses
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_reg[i] <= 1'b0;
        ctr_reg[i]   <= 2'b01;
      end
    end else if (bp.upd_valid) begin
      if (upd_hit) begin
        target_reg[upd_idx] <= bp.upd_target;
        type_reg[upd_idx]   <= upd_type;
        if (upd_type == T_COND) ctr_reg[upd_idx] <= ctr_next;
      end else if (bp.upd_taken) begin
        valid_reg[upd_idx]  <= 1'b1;
        tag_reg[upd_idx]    <= upd_tag;
        target_reg[upd_idx] <= bp.upd_target;
        type_reg[upd_idx]   <= upd_type;
        ctr_reg[upd_idx]    <= (upd_type == T_COND) ? 2'b10 : 2'b11;
      end
    end
  end

  // RAS: a mispredict flushes the stack ahead of any same-cycle push or pop;
  // a push on a full stack wraps and overwrites the oldest slot
  always_ff @(posedge clk) begin
    if (rst || ras_clear) begin
      tp_reg  <= '0;
      cnt_reg <= '0;
    end else if (ras_push) begin
      ras_reg[tp_inc] <= pred_seq;
      tp_reg          <= tp_inc;
      if (cnt_reg != RAS_FULL) cnt_reg <= cnt_reg + 1'b1;
    end else if (ras_pop) begin
      tp_reg  <= tp_reg - 1'b1;
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  // PCs are word aligned; the low bits carry no information
  logic unused_ok;
  assign unused_ok = ^{bp.pred_pc[1:0], bp.upd_pc[1:0]};

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage branch predictor that produces the next-PC guess which the execute-stage branch unit later confirms or refutes. It has four parts: a direct-mapped BTB, per-entry 2-bit saturating direction counters, and a small return-address stack (RAS) that predicts at fetch, plus a training port. The training port receives each resolved branch from execute: PC, `bru_op_t` operation, actual taken outcome, actual target and mispredict flag.

## Interface
- `BTB_ENTRIES`, 64: number of BTB entries. Must be a power of two, at least 4.
- `RAS_DEPTH`, 8: number of RAS entries. Must be a power of two, at least 2.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `pred_valid` in 1: the fetch PC is valid this cycle. Gates RAS push/pop only.
- `pred_pc` in 32 (`u32_t`): fetch PC, word aligned.
- `pred_taken` out 1: predicted taken.
- `pred_target` out 32 (`u32_t`): predicted next PC.
- `upd_valid` in 1: a resolved branch is presented this cycle.
- `upd_pc` in 32 (`u32_t`): PC of the resolved branch.
- `upd_op` in `bru_op_t`: BEQ/BNE/BLT/BLTU/BGE/BGEU/B/BL/JIRL.
- `upd_ret` in 1: the JIRL is a return (rd=r0, rj=r1, offset 0). Ignored for other ops.
- `upd_taken` in 1: actual outcome from the branch unit.
- `upd_target` in 32 (`u32_t`): actual target.
- `upd_mispredict` in 1: fetch was redirected for this branch.

## Operation
- Index is `pc[IW+1:2]`, where IW = log2(BTB_ENTRIES).
- Tag is `pc[31:IW+2]`.
- Each entry holds: valid, tag, target[31:0], type {COND, JUMP, CALL, RET}, ctr[1:0].
- Type mapping:
  - BEQ..BGEU → COND
  - B → JUMP
  - BL → CALL
  - JIRL with upd_ret=1 → RET
  - JIRL with upd_ret=0 → JUMP (indirect; last target predicted)
- Lookup is combinational on `pred_pc`. hit = valid & tag match.
  - Miss: taken=0.
  - COND: taken = ctr[1], target = entry target.
  - JUMP or CALL: taken=1, target = entry target.
  - RET: taken=1. Target is the RAS top if the RAS is non-empty; otherwise the entry target.
  - Whenever taken=0: pred_target = pred_pc + 4, computed mod 2^32 (0xFFFFFFFC wraps to 0x00000000).
- The RAS is a circular buffer with top pointer `tp` and occupancy `cnt` (0..RAS_DEPTH).
  - Push (pred_valid & hit & CALL): write pred_pc+4 at tp+1, advance tp, cnt = min(cnt+1, RAS_DEPTH). When full, the oldest entry is silently overwritten.
  - Pop (pred_valid & hit & RET & cnt≠0): move tp back, decrement cnt.
  - Pop while empty: no state change.
  - At most one push or pop per cycle by construction.
- Training on upd_valid, at the upd_pc index:
  - Hit: overwrite target and type. For COND, ctr saturates: +1 if taken (stops at 3), −1 if not taken (stops at 0). Non-COND types leave ctr unchanged.
  - Miss with upd_taken=1: allocate (overwrite) the entry with valid=1, new tag, target, type. ctr = 2'b10 for COND, 2'b11 otherwise.
  - Miss with upd_taken=0: no write.
- Mispredict recovery: upd_valid & upd_mispredict clears the RAS (cnt=0, tp=0) at the same edge. This takes priority over any same-cycle push or pop.
- Reset: all valid bits=0, all ctr=2'b01, RAS cnt=0, tp=0.
  - rst has priority over training and RAS activity.
  - Reset mid-operation discards any in-flight update.

## Timing
- Lookup outputs are combinational from pred_pc and the current state, with zero latency.
- All table and RAS writes occur at the rising clk edge and are visible to lookups from the next cycle.
- Same-cycle read and write of one index: the lookup returns the pre-update contents.
- Outputs after reset, for any pred_pc: pred_taken=0, pred_target=pred_pc+4.
- Back-to-back updates to the same index each apply in order, one per cycle. A counter at 3 stays at 3 after repeated taken outcomes; at 0 it stays at 0 after repeated not-taken outcomes.
- No handshake or stalls: update is accepted every cycle, and lookup is always ready.

## Test plan
- **Reset defaults:** assert rst for 2 cycles, then pred_pc=0x1C000000 → pred_taken=0, pred_target=0x1C000004. Also pred_pc=0xFFFFFFFC → pred_target=0x00000000.
- **COND training:**
  - Update pc=0x1C000010, BEQ, taken, target 0x1C000100 → next cycle lookup gives taken=1 (ctr=2), target 0x1C000100.
  - Two not-taken updates → taken=0 (ctr=0).
  - A third not-taken update keeps ctr=0; one taken update then gives ctr=1, taken=0.
  - Not-taken BNE at miss pc 0x1C000020 → still miss.
- **Aliasing:** after allocating pc 0x1C000010, update taken B at 0x1C000010 + 4·BTB_ENTRIES → the original PC now misses and the new PC hits as JUMP.
- **RAS:**
  - Train BL at 0x1C000040 and RET JIRL at 0x1C000200.
  - Lookup 0x1C000040 (pred_valid) → push 0x1C000044. Lookup 0x1C000200 → pred_target=0x1C000044, RAS empty afterward.
  - A second RET lookup with the RAS empty → BTB target.
- **RAS overflow:** RAS_DEPTH+1 CALL lookups at distinct trained PCs, then RAS_DEPTH RET lookups → the most recent RAS_DEPTH return addresses come back in LIFO order. The first-pushed return address is lost.
- **Recovery and same-cycle:**
  - upd_mispredict=1 in the same cycle as a CALL lookup → RAS empty the next cycle.
  - A same-index update and lookup in one cycle → the lookup shows the old entry, and the new entry appears the next cycle.
